// File: rtl/imem_stall_resp.sv
`default_nettype none
// ============================================================================
//  Module   : imem_stall_resp
//  Purpose  : Multi-cycle instruction memory responder with a stall/done
//             handshake, a preload write path and unaligned-access error.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_stall_resp #(
  parameter int unsigned LATENCY    = 4,  // 2..15
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [15:0] data_in_i,
  output logic [15:0] data_out_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned c_CNT_W = 4;
  localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic [DEPTH_LOG2:0]   addr_q, addr_d;   // word index plus byte bit 0
  logic                  wr_q, wr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  stall_q, stall_d;
  logic                  err_q, err_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  w_mem_we;

  logic [15:0] mem_q [2**DEPTH_LOG2];

  // Address bits above the word index are intentionally ignored (wrap).
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^addr_i[15:DEPTH_LOG2+1];

  // Next-state logic: accept in IDLE, count down in BUSY, complete on reaching 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    stall_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    w_mem_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_i && wr_i) begin
          // Conflicting request: flag it, touch nothing.
          err_d = 1'b1;
        end else if (rd_i || wr_i) begin
          state_d = ST_BUSY;
          cnt_d   = c_LOAD;
          addr_d  = addr_i[DEPTH_LOG2:0];
          wr_d    = wr_i;
          wdata_d = data_in_i;
          stall_d = 1'b1;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - c_ONE;
        if (cnt_q == c_ONE) begin
          // Counter reaches 0 on this edge: the done cycle follows.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = addr_q[0];
          if (!addr_q[0]) begin
            if (wr_q) begin
              w_mem_we = 1'b1;
            end else begin
              rdata_d = mem_q[addr_q[DEPTH_LOG2:1]];
            end
          end
        end else begin
          stall_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; contents survive reset, a write under reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      mem_q[addr_q[DEPTH_LOG2:1]] <= wdata_q;
    end
  end

  assign data_out_o = rdata_q;
  assign done_o     = done_q;
  assign stall_o    = stall_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_stall_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_stall_resp
//  Purpose  : Self-checking bench for imem_stall_resp (directed table plus
//             randomized traffic against a transaction-level model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_stall_resp;

  localparam int L  = 4;
  localparam int DL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr_i = '0;
  logic        rd_i = 1'b0;
  logic        wr_i = 1'b0;
  logic [15:0] data_in_i = '0;
  logic [15:0] data_out_o;
  logic        done_o, stall_o, err_o;

  imem_stall_resp #(.LATENCY(L), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .rd_i(rd_i), .wr_i(wr_i),
    .data_in_i(data_in_i), .data_out_o(data_out_o), .done_o(done_o),
    .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- transaction-level reference model ----------------
  logic [15:0] m_mem [2**DL];
  bit          m_pend = 0;
  int          m_edge = 0;
  int          m_done_at = 0;
  bit          m_wr;
  int          m_addr;
  logic [15:0] m_din;
  logic        e_done, e_stall, e_err;
  logic [15:0] e_data;

  function automatic logic [15:0] pat(int i);
    return 16'(i * 257) ^ 16'hC3A5;
  endfunction

  // Expected outputs right after this edge given inputs held before it.
  function automatic void model_step(logic r, logic rd, logic wr, logic [15:0] a, logic [15:0] d);
    int idx;
    e_done = 0; e_stall = 0; e_err = 0; e_data = 0;
    if (r) begin
      m_pend = 0;
    end else if (m_pend) begin
      if (m_edge == m_done_at) begin
        idx = (m_addr % (2 ** (DL + 1))) / 2;
        e_done = 1;
        e_err  = (m_addr % 2) == 1;
        if (!e_err) begin
          if (m_wr) m_mem[idx] = m_din;
          else      e_data = m_mem[idx];
        end
        m_pend = 0;
      end else begin
        e_stall = 1;
      end
    end else if (rd && wr) begin
      e_err = 1;
    end else if (rd || wr) begin
      m_pend = 1;
      m_done_at = m_edge + L - 1;
      m_wr = wr;
      m_addr = int'(a);
      m_din = d;
      e_stall = 1;
    end
    m_edge++;
  endfunction

  // One clock: drive inputs, advance model at the edge, sample #1 later.
  task automatic step(logic r, logic rd, logic wr, logic [15:0] a, logic [15:0] d);
    rst = r; rd_i = rd; wr_i = wr; addr_i = a; data_in_i = d;
    @(posedge clk);
    model_step(r, rd, wr, a, d);
    #1;
  endtask

  task automatic chk(string name, logic xd, logic xs, logic xe, logic [15:0] xdat);
    n_tests++;
    if ({done_o, stall_o, err_o, data_out_o} !== {xd, xs, xe, xdat}) begin
      n_fail++;
      $display("FAIL %s: got done=%b stall=%b err=%b data=%h, want done=%b stall=%b err=%b data=%h",
               name, done_o, stall_o, err_o, data_out_o, xd, xs, xe, xdat);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, rd, wr;
    logic [15:0] a, d;
    logic        xd, xs, xe;
    logic [15:0] xdat;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(logic r, logic rd, logic wr, logic [15:0] a, logic [15:0] d,
                              logic xd, logic xs, logic xe, logic [15:0] xdat);
    vec_t v;
    v.r = r; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
    v.xd = xd; v.xs = xs; v.xe = xe; v.xdat = xdat;
    tbl.push_back(v);
  endfunction

  function automatic void op(logic rd, logic wr, logic [15:0] a, logic [15:0] d,
                             logic xe, logic [15:0] xdat);
    row(0, rd, wr, a, d, 0, 1, 0, 16'h0);
    for (int k = 0; k < L - 2; k++) row(0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h0);
    row(0, 0, 0, 16'h0, 16'h0, 1, 0, xe, xdat);
  endfunction

  function automatic void idle(int n);
    for (int k = 0; k < n; k++) row(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
  endfunction

  initial begin
    // Reset state
    step(1, 0, 0, 16'h0, 16'h0);
    chk("reset", 0, 0, 0, 16'h0);

    // Preload every word with a known pattern, checked against the model
    for (int i = 0; i < 2 ** DL; i++) begin
      step(0, 0, 1, 16'(2 * i), pat(i));
      for (int k = 0; k < L - 1; k++) begin
        step(0, 0, 0, 16'h0, 16'h0);
        chk("preload", e_done, e_stall, e_err, e_data);
      end
    end

    // Build directed table
    op(0, 1, 16'h0000, 16'h1111, 0, 16'h0);
    op(0, 1, 16'h0002, 16'hBEEF, 0, 16'h0);
    op(1, 0, 16'h0002, 16'h0, 0, 16'hBEEF);
    // back-to-back reads, rd held through the done cycle
    row(0, 1, 0, 16'h0000, 16'h0, 0, 1, 0, 16'h0);
    row(0, 1, 0, 16'h0000, 16'h0, 0, 1, 0, 16'h0);
    row(0, 1, 0, 16'h0000, 16'h0, 0, 1, 0, 16'h0);
    row(0, 1, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h1111);
    row(0, 1, 0, 16'h0002, 16'h0, 0, 1, 0, 16'h0);
    row(0, 1, 0, 16'h0002, 16'h0, 0, 1, 0, 16'h0);
    row(0, 1, 0, 16'h0002, 16'h0, 0, 1, 0, 16'h0);
    row(0, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 16'hBEEF);
    idle(1);
    // unaligned read, suppressed unaligned write, prior contents intact
    op(1, 0, 16'h0003, 16'h0, 1, 16'h0);
    op(0, 1, 16'h0005, 16'hAAAA, 1, 16'h0);
    op(1, 0, 16'h0004, 16'h0, 0, pat(2));
    // conflict in IDLE, then memory untouched
    row(0, 1, 1, 16'h0000, 16'hFFFF, 0, 0, 1, 16'h0);
    idle(1);
    op(1, 0, 16'h0000, 16'h0, 0, 16'h1111);
    // new rd raised while stalled is ignored
    row(0, 1, 0, 16'h0000, 16'h0, 0, 1, 0, 16'h0);
    row(0, 0, 0, 16'h0000, 16'h0, 0, 1, 0, 16'h0);
    row(0, 1, 0, 16'h0002, 16'h0, 0, 1, 0, 16'h0);
    row(0, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h1111);
    idle(4);
    // address wrap
    op(0, 1, 16'h0202, 16'h1234, 0, 16'h0);
    op(1, 0, 16'h0002, 16'h0, 0, 16'h1234);
    // reset mid-write drops the write
    row(0, 0, 1, 16'h0010, 16'h5555, 0, 1, 0, 16'h0);
    row(0, 0, 0, 16'h0000, 16'h0, 0, 1, 0, 16'h0);
    row(1, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0);
    idle(4);
    op(1, 0, 16'h0010, 16'h0, 0, pat(8));
    // reset wins over a simultaneous request
    row(1, 1, 0, 16'h0002, 16'h0, 0, 0, 0, 16'h0);
    idle(4);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].xd, tbl[i].xs, tbl[i].xe, tbl[i].xdat);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic        r, rd, wr;
      logic [15:0] a;
      int          k;
      r  = ($urandom_range(0, 63) == 0);
      k  = $urandom_range(0, 9);
      rd = (k <= 3) || (k == 7);
      wr = (k >= 4 && k <= 7);
      a  = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      step(r, rd, wr, a, 16'($urandom));
      chk("random", e_done, e_stall, e_err, e_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_stall_resp.md
# imem_stall_resp

Multi-cycle instruction-memory responder that answers fetch-stage read requests with a fixed, parameterised latency and a stall/done handshake. It replaces the single-cycle instruction memory behind the PC register, so the fetch logic must hold `addr` and wait on `stall`/`done`. A write path lets the bench preload program words. Unaligned accesses are reported on `err` together with `done`.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `done`; legal range 2..15.
- `DEPTH_LOG2`, 8: log2 of the number of 16-bit words stored.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `addr`  in  16  byte address; word index = `addr[DEPTH_LOG2:1]`
- `rd`  in  1  read request
- `wr`  in  1  write request (preload)
- `data_in`  in  16  write data
- `data_out`  out  16  read data; valid only while `done`=1
- `done`  out  1  one-cycle completion pulse
- `stall`  out  1  high while a request is in flight
- `err`  out  1  one-cycle error pulse

## Operation
- States: IDLE, BUSY. All outputs are registered.
- Acceptance: a request is accepted in a cycle where the state is IDLE, or where the state is BUSY and `done`=1 that cycle (back-to-back), and exactly one of `rd`/`wr` is high.
  - On acceptance, latch `addr`, the op and `data_in`.
  - Load the down-counter with `LATENCY`-1 and go to BUSY.
- Requests that arrive while `stall`=1 are ignored. The requester must hold them.
- `rd`=`wr`=1 in an acceptance cycle: the request is rejected and memory is untouched. `err` pulses the next cycle with `done`=0, and the state stays IDLE.
- BUSY: the counter decrements each cycle.
  - When the counter reaches 0, the state returns to IDLE.
  - On that transition, `done` is driven 1 for one cycle. If no new request is accepted that cycle, `stall` drops.
- Read completion: `data_out` = mem[latched word index] for the `done` cycle. In all other cycles `data_out` = 0.
- Write completion: mem[latched index] ← latched data at the edge that produces `done`. `data_out` = 0.
- Unaligned access (latched `addr[0]`=1): full latency still applies.
  - `done`=1 and `err`=1 in the same cycle, with `data_out`=0.
  - A write is suppressed.
- Address bits above `DEPTH_LOG2` are ignored, so addresses wrap modulo 2^(`DEPTH_LOG2`+1) bytes.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values: state IDLE, counter 0, `done`=0, `stall`=0, `err`=0, `data_out`=0.
- Request accepted at edge T:
  - `stall`=1 in cycles T+1 .. T+`LATENCY`-1.
  - `done` (and, if applicable, `err`) = 1 in cycle T+`LATENCY`.
- Back-to-back: a request presented during the `done` cycle is accepted. Sustained throughput is one request per `LATENCY` cycles.
- Read-after-write to the same address, issued back-to-back, returns the new data.
- `rst` asserted mid-BUSY: the request is aborted. No `done` is produced, a pending write is dropped, and the next cycle is IDLE with all outputs at reset values.
- `rst` has priority over any request in the same cycle.

## Test plan
- Preload: write 0x1111 @0x0000, then 0xBEEF @0x0002, with `LATENCY`=4.
  - Read @0x0002 → `done`=1 exactly 4 cycles after acceptance, `data_out`=0xBEEF, `stall`=1 for the 3 intervening cycles, `err`=0.
- Back-to-back: read @0x0000 and hold `rd` through the `done` cycle with `addr`=0x0002.
  - → `done` pulses at T+4 (0x1111) and T+8 (0xBEEF).
  - → `stall` stays 1 from T+1 through T+7 except T+4.
- Unaligned: read @0x0003 → `done`=1, `err`=1, `data_out`=0 at T+4.
  - A subsequent write @0x0005 of 0xAAAA is suppressed: reading @0x0004 still returns the prior contents.
- Conflict and ignore:
  - `rd`=`wr`=1 in IDLE → `err` pulse next cycle, `done`=0, `stall`=0.
  - A new `rd` raised while `stall`=1 → no extra `done`.
- Wrap: `DEPTH_LOG2`=8; write 0x1234 @0x0202, read @0x0002 → 0x1234.
- Reset mid-op: start a write of 0x5555 @0x0010 and assert `rst` at T+2.
  - → no `done`, all outputs 0 the next cycle.
  - → reading @0x0010 returns the old value.
